// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, error codes, command/response bytes, helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SEND,
        ST_ACK_WAIT,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_NORESP  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_NOACK   = 2'b11;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;

    localparam int TMR_W = 20;

    // PS/2 frames carry odd parity over the eight data bits plus the parity bit
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Timer increment that sticks at all-ones instead of wrapping
    function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
        return (&v) ? v : v + TMR_W'(1);
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-side handshake and status bundle for the PS/2 host transmitter.
// Latency: n/a (wires only).
// Backpressure: valid/ready; tx_ready low whenever the transmitter owns the bus.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       rx_inhibit;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, rx_inhibit, done, err, err_code
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, rx_inhibit, done, err, err_code
    );
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line plus a 1->0 edge strobe.
// Latency: sync valid 2 cycles after the pin, fall strobe in the same cycle sync drops.
// Backpressure: none; free-running.
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Resample the pin twice, keep one older copy to spot falling edges; idle bus reads high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync = sync_q;
    assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 11-bit frame, ack check.
// Latency: clock held low INHIBIT_CYCLES, then device paced; data line moves 3 cycles after a pin fall.
// Backpressure: tx_ready only in IDLE; tx_valid ignored while busy, one byte per accept.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES      = 5000,
    parameter int RTS_TIMEOUT_CYCLES  = 750000,
    parameter int XFER_TIMEOUT_CYCLES = 100000
) (
    input  logic         clk,
    input  logic         reset,
    ps2_host_tx_if.slave bus,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);

    // Last counter values before each phase ends (counter starts at 0 on phase entry)
    localparam logic [TMR_W-1:0] INH_LAST  = TMR_W'(INHIBIT_CYCLES - 2);
    localparam logic [TMR_W-1:0] RTS_LAST  = TMR_W'(RTS_TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] XFER_LAST = TMR_W'(XFER_TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [7:0]       data_q;
    logic             parity_q;
    logic [3:0]       bit_cnt;
    logic [TMR_W-1:0] cnt;
    logic             tx_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [1:0]       err_code_q;
    logic             timeout;

    logic clk_sync;
    logic clk_fall;
    logic data_sync;
    logic unused_data_fall;

    ps2_line_sync u_clk_sync (
        .clk   (clk),
        .reset (reset),
        .din   (ps2_clk_in),
        .sync  (clk_sync),
        .fall  (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk   (clk),
        .reset (reset),
        .din   (ps2_data_in),
        .sync  (data_sync),
        .fall  (unused_data_fall)
    );

    // Before the first device edge the no-response limit applies, afterwards the whole-frame limit
    always_comb begin
        timeout = 1'b0;
        if (bit_cnt == 4'd0) timeout = (cnt == RTS_LAST);
        else                 timeout = (cnt == XFER_LAST);
    end

    // Transmit sequencer with registered line drives and status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            data_q      <= 8'h00;
            parity_q    <= 1'b0;
            bit_cnt     <= 4'd0;
            cnt         <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.tx_valid && tx_ready_q) begin
                        data_q     <= bus.tx_data;
                        parity_q   <= odd_parity(bus.tx_data);
                        err_code_q <= ERR_NONE;
                        cnt        <= '0;
                        tx_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        state      <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    // Data drops in the final held-low cycle so it leads the clock release by one
                    if (cnt == INH_LAST) begin
                        ps2_data_oe <= 1'b1;
                        state       <= ST_RTS;
                    end else begin
                        cnt <= cnt + TMR_W'(1);
                    end
                end
                ST_RTS: begin
                    ps2_clk_oe <= 1'b0;
                    cnt        <= '0;
                    bit_cnt    <= 4'd0;
                    state      <= ST_SEND;
                end
                ST_SEND: begin
                    if (timeout) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        err_q       <= 1'b1;
                        err_code_q  <= (bit_cnt == 4'd0) ? ERR_NORESP : ERR_TIMEOUT;
                        state       <= ST_ERR;
                    end else if (clk_fall) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        cnt     <= (bit_cnt == 4'd0) ? '0 : sat_inc(cnt);
                        if (bit_cnt < 4'd8) begin
                            ps2_data_oe <= ~data_q[bit_cnt[2:0]];
                        end else if (bit_cnt == 4'd8) begin
                            ps2_data_oe <= ~parity_q;
                        end else if (bit_cnt == 4'd9) begin
                            ps2_data_oe <= 1'b0;
                        end else if (data_sync) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_NOACK;
                            state      <= ST_ERR;
                        end else begin
                            state <= ST_ACK_WAIT;
                        end
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                ST_ACK_WAIT: begin
                    if (timeout) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        err_q       <= 1'b1;
                        err_code_q  <= ERR_TIMEOUT;
                        state       <= ST_ERR;
                    end else if (clk_sync && data_sync) begin
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                ST_DONE, ST_ERR: begin
                    tx_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    tx_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_ready   = tx_ready_q;
    assign bus.busy       = busy_q;
    assign bus.rx_inhibit = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.err_code   = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int INH     = 40;
    localparam int RTS_TO  = 1500;
    localparam int XFER_TO = 800;
    localparam int HALF    = 15;

    typedef struct {
        bit         is_err;
        logic [1:0] code;
    } resp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic ps2_clk_in;
    logic ps2_data_in;
    logic ps2_clk_oe;
    logic ps2_data_oe;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   accepts = 0;
    int   resp_cyc = 0;
    logic busy_prev = 1'b0;

    resp_t      exp_q[$];
    logic [9:0] frame_q[$];

    ps2_host_tx_if bus();

    ps2_host_tx #(
        .INHIBIT_CYCLES      (INH),
        .RTS_TIMEOUT_CYCLES  (RTS_TO),
        .XFER_TIMEOUT_CYCLES (XFER_TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    // Open-drain wiring: a line is low if either side pulls it
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference frame as the device should see it: 8 data bits LSB first, odd parity, stop 1
    function automatic logic [9:0] frame_of(input logic [7:0] d);
        logic [9:0] f;
        f[7:0] = d;
        f[8]   = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        f[9]   = 1'b1;
        return f;
    endfunction

    // Scoreboard monitor: every done/err pulse consumes one expected response
    initial begin : monitor
        resp_t e;
        forever begin
            @(negedge clk);
            if (bus.busy === 1'b1 && busy_prev !== 1'b1) accepts++;
            busy_prev = bus.busy;
            if (reset === 1'b0 && (bus.done === 1'b1 || bus.err === 1'b1)) begin
                pulses++;
                resp_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse done=%0b err=%0b code=%b", bus.done, bus.err, bus.err_code);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_is_err", 32'(bus.err), 32'(e.is_err));
                    check("resp_done", 32'(bus.done), 32'(!e.is_err));
                    check("resp_err_code", 32'(bus.err_code), 32'(e.code));
                end
            end
        end
    end

    // Present a byte, then measure the clock-inhibit hold and the data lead before release
    task automatic issue(input logic [7:0] d, input bit keep, output int rel_cyc);
        int hold;
        int dfirst;
        @(negedge clk);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        check("ready_low_after_accept", 32'(bus.tx_ready), 32'd0);
        check("clk_oe_after_accept", 32'(ps2_clk_oe), 32'd1);
        if (keep) bus.tx_data = ~d;
        else      bus.tx_valid = 1'b0;
        hold   = 0;
        dfirst = -1;
        while (ps2_clk_oe === 1'b1 && hold < 10 * INH) begin
            hold++;
            if (ps2_data_oe === 1'b1 && dfirst < 0) dfirst = hold;
            @(negedge clk);
        end
        rel_cyc = cyc;
        check("inhibit_hold_cycles", 32'(hold), 32'(INH));
        check("data_oe_lead_cycle", 32'(dfirst), 32'(INH));
    endtask

    // Device model: waits for request-to-send, clocks n_edges bits, samples on each rise
    task automatic device(input int n_edges, input bit ack, output int e1_cyc);
        logic [9:0] got;
        int         t;
        got    = '0;
        e1_cyc = cyc;
        t      = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("rts_seen", 32'(t < 5000), 32'd1);
        repeat (10) @(negedge clk);
        for (int k = 1; k <= n_edges; k++) begin
            dev_clk = 1'b0;
            if (k == 1) e1_cyc = cyc;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (k <= 10) got[k-1] = ps2_data_in;
            if (k == 10 && ack) dev_data = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        dev_data = 1'b1;
        if (n_edges == 11) begin
            if (frame_q.size() == 0) check("frame_expected_present", 32'd0, 32'd1);
            else                     check("frame_bits", 32'(got), 32'(frame_q.pop_front()));
        end
    endtask

    task automatic wait_pulse(input int p0, input int limit, input string name);
        int t;
        t = 0;
        while (pulses == p0 && t < limit) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(pulses - p0), 32'd1);
    endtask

    task automatic send_ok(input logic [7:0] d);
        int rel;
        int e1;
        int p0;
        p0 = pulses;
        exp_q.push_back('{1'b0, 2'b00});
        frame_q.push_back(frame_of(d));
        issue(d, 1'b0, rel);
        device(11, 1'b1, e1);
        wait_pulse(p0, 200, "done_pulse_seen");
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : stim
        int         rel;
        int         e1;
        int         p0;
        int         a0;
        int         t;
        logic [7:0] d;

        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_rx_inhibit", 32'(bus.rx_inhibit), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_err_code", 32'(bus.err_code), 32'd0);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_data_oe", 32'(ps2_data_oe), 32'd0);

        // Set-LEDs and a low-parity byte, both acknowledged
        send_ok(8'hED);
        send_ok(8'h07);

        // Device never clocks
        p0 = pulses;
        exp_q.push_back('{1'b1, 2'b01});
        issue(8'hEE, 1'b0, rel);
        wait_pulse(p0, RTS_TO + 100, "noresp_pulse_seen");
        check("noresp_latency", 32'(resp_cyc - rel), 32'(RTS_TO));
        check("noresp_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("noresp_data_oe", 32'(ps2_data_oe), 32'd0);

        // Device stops after five edges; limit counts from edge 1 as seen past the synchronizer
        p0 = pulses;
        exp_q.push_back('{1'b1, 2'b10});
        issue(8'h55, 1'b0, rel);
        device(5, 1'b0, e1);
        wait_pulse(p0, XFER_TO + 100, "xfer_timeout_pulse_seen");
        check("xfer_timeout_latency", 32'(resp_cyc - e1), 32'(XFER_TO + 3));

        // Device leaves data high at edge 11
        p0 = pulses;
        exp_q.push_back('{1'b1, 2'b11});
        frame_q.push_back(frame_of(8'h3C));
        issue(8'h3C, 1'b0, rel);
        device(11, 1'b0, e1);
        wait_pulse(p0, 200, "noack_pulse_seen");
        repeat (20) @(negedge clk);
        check("err_code_holds", 32'(bus.err_code), 32'd3);

        // A clean reset command clears the code
        send_ok(8'hFF);
        check("err_code_cleared", 32'(bus.err_code), 32'd0);

        // Reset mid-frame after edge 4 (bit 3 of 0xA5 is 0, so data is being pulled)
        p0 = pulses;
        issue(8'hA5, 1'b0, rel);
        device(4, 1'b0, e1);
        check("pre_reset_data_oe", 32'(ps2_data_oe), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("reset_data_oe", 32'(ps2_data_oe), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_tx_ready", 32'(bus.tx_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        check("reset_no_pulse", 32'(pulses - p0), 32'd0);

        // tx_valid held through the whole frame: exactly one accept
        d  = 8'($urandom_range(0, 255));
        a0 = accepts;
        p0 = pulses;
        exp_q.push_back('{1'b0, 2'b00});
        frame_q.push_back(frame_of(d));
        issue(d, 1'b1, rel);
        device(11, 1'b1, e1);
        t = 0;
        while (bus.done !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        bus.tx_valid = 1'b0;
        check("held_valid_done_seen", 32'(bus.done), 32'd1);
        repeat (60) @(negedge clk);
        check("held_valid_one_accept", 32'(accepts - a0), 32'd1);
        check("held_valid_one_pulse", 32'(pulses - p0), 32'd1);
        check("held_valid_idle", 32'(bus.busy), 32'd0);

        // Random bytes
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom_range(0, 255));
            send_ok(d);
        end

        repeat (10) @(negedge clk);
        check("all_responses_seen", 32'(exp_q.size()), 32'd0);
        check("all_frames_seen", 32'(frame_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard on the same PS2_CLK/PS2_DATA lines that `keyboard_ps2` receives on. Runs in the 50 MHz keyboard domain. Drives both lines open-drain: the top level ties each pin to 0 when its `_oe` is high and to Z otherwise. Reports completion, device acknowledge, or a coded error, and holds `rx_inhibit` high so the receiver discards any partial frame while the host owns the bus.

## Interface
- INHIBIT_CYCLES, 5000: clock-low hold before request-to-send (100 µs at 50 MHz).
- RTS_TIMEOUT_CYCLES, 750000: maximum wait from clock release to the device's first falling edge (15 ms).
- XFER_TIMEOUT_CYCLES, 100000: maximum time from the first falling edge to end of frame (2 ms).
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high.
- tx_data  in  8  command byte, sampled on accept.
- tx_valid  in  1  request.
- tx_ready  out  1  high only in IDLE.
- ps2_clk_in  in  1  raw PS/2 clock pin.
- ps2_data_in  in  1  raw PS/2 data pin.
- ps2_clk_oe  out  1  1 = pull clock low.
- ps2_data_oe  out  1  1 = pull data low.
- busy  out  1  high in every state except IDLE.
- rx_inhibit  out  1  equals busy.
- done  out  1  one-cycle pulse, frame finished and acknowledged.
- err  out  1  one-cycle pulse, frame failed.
- err_code  out  2  01 no response, 10 transfer timeout, 11 no ack; holds until the next accept.

## Operation
- Inputs pass through a 2-FF synchronizer. A falling edge is a synchronized 1→0 transition.
- Accept occurs when tx_valid && tx_ready. On accept: latch tx_data, compute parity = ~^tx_data (odd), clear err_code. tx_valid is ignored while busy.
- States:
  - IDLE: both oe = 0.
  - INHIBIT: clk_oe = 1 for INHIBIT_CYCLES.
  - RTS: clk_oe = 1 and data_oe = 1 for one cycle, then clk_oe = 0 with data_oe still 1 (start bit). Move to SEND.
  - SEND: bit counter 0..10, advanced on each falling edge.
    - Edges 1–8: data_oe = ~tx_data[edge-1], LSB first.
    - Edge 9: data_oe = ~parity.
    - Edge 10: data_oe = 0 (stop bit, line released).
    - Edge 11: sample synchronized data. 0 → ACK_WAIT. 1 → ERR with code 11.
  - ACK_WAIT: wait for synchronized clk = 1 and data = 1, then DONE.
  - DONE: pulse done, return to IDLE.
  - ERR: release both lines, pulse err, return to IDLE.
- Timeouts:
  - RTS_TIMEOUT_CYCLES elapsing in SEND before edge 1 → ERR, code 01.
  - XFER_TIMEOUT_CYCLES elapsing from edge 1 without reaching DONE (including ACK_WAIT) → ERR, code 10.
- A device-originated frame in progress when a request is accepted is aborted by the inhibit. This is legal PS/2; rx_inhibit covers the receiver.
- Reset mid-operation: both oe drop to 0 immediately (asynchronous), state returns to IDLE, no done/err pulse.

## Timing
- Reset values: ps2_clk_oe 0, ps2_data_oe 0, busy 0, rx_inhibit 0, done 0, err 0, err_code 00, tx_ready 1.
- Accept at cycle N:
  - tx_ready = 0 and clk_oe = 1 from N+1.
  - clk_oe stays 1 for exactly INHIBIT_CYCLES cycles.
  - data_oe rises one cycle before clk_oe falls.
- Falling edge on the pin → data_oe update 3 cycles later: 2 sync plus 1 register. This is well inside the ~30 µs low phase.
- done/err pulse 1 cycle after the terminating condition. tx_ready returns the cycle after the pulse.
- Timeout counters are 20 bits and do not wrap. Each counter saturates at its limit.
- Simultaneous falling edge and timeout expiry on the same cycle: the timeout wins.

## Structure
- Shared package ps2_pkg holds:
  - state enum;
  - err_code constants ERR_NONE, ERR_NORESP, ERR_TIMEOUT, ERR_NOACK;
  - command constants CMD_SET_LEDS 8'hED, CMD_ECHO 8'hEE, CMD_RESET 8'hFF;
  - response constants RSP_ACK 8'hFA, RSP_RESEND 8'hFE.
- Sub-module ps2_line_sync (2-FF synchronizer plus falling-edge detector, one instance per line). The receiver reuses the same module.

## Test plan
- Send 0xED with a device model clocking at 80 µs/bit that acks. Device samples 1,0,1,1,0,1,1,1 then parity 1 then stop 1. done pulses, err_code = 00.
- Send 0x07: sampled parity = 0, clk_oe low-hold measured as exactly 5000 cycles, data_oe asserted before clk_oe release.
- Device never clocks → err pulse at 750000 cycles after clock release, err_code = 01, both oe = 0.
- Device stops after edge 5 → err with err_code = 10 at 100000 cycles after edge 1.
- Device leaves data high at edge 11 → err_code = 11. Then send 0xFF successfully: err_code clears to 00, done pulses.
- Assert reset during SEND after edge 4 → oe lines 0 in the same cycle, busy 0, no pulses. Hold tx_valid through busy: exactly one frame transmitted.
